// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer.
// Samples a take condition at an instruction boundary, then acknowledges
// the controller, redirects fetch to the aligned handler vector, and
// tracks handler execution until reti redirects back to the saved PC.
module int_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq,
  input  logic [31:0] vec_addr,
  input  logic        int_en,
  input  logic        instr_boundary,
  input  logic [31:0] pc_cur,
  input  logic        reti,
  output logic        iack,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic [31:0] epc,
  output logic        in_isr,
  output logic        stall,
  output logic [7:0]  irq_count,
  output logic        reti_err
);

  typedef enum logic [2:0] {IDLE, ACK, REDIRECT, ISR, RETURN} state_t;

  state_t      state, state_nxt;
  logic [31:0] latched_vec;
  logic        take;
  logic        reti_bad;

  // take is only meaningful in IDLE; irq is a level that stays up through ACK
  assign take     = irq & int_en & instr_boundary;
  assign reti_bad = reti & ((state == IDLE) | (state == ACK) | (state == REDIRECT));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (take) state_nxt = ACK;
      ACK:      state_nxt = REDIRECT;
      REDIRECT: state_nxt = ISR;
      ISR:      if (reti) state_nxt = RETURN;
      RETURN:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // vector/return-address capture, taken-interrupt counter, reti error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      latched_vec <= '0;
      epc         <= '0;
      irq_count   <= '0;
      reti_err    <= 1'b0;
    end else begin
      if (state == IDLE && take) begin
        latched_vec <= vec_addr;
        epc         <= pc_cur;
      end
      if (state == REDIRECT && irq_count != 8'hFF)
        irq_count <= irq_count + 8'd1;
      reti_err <= reti_bad;
    end
  end

  // state-decoded strobes; pc_target is forced to 0 outside a redirect
  always_comb begin
    iack        = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    in_isr      = 1'b0;
    stall       = 1'b0;
    case (state)
      ACK: begin
        iack  = 1'b1;
        stall = 1'b1;
      end
      REDIRECT: begin
        pc_redirect = 1'b1;
        stall       = 1'b1;
        pc_target   = {latched_vec[31:5], 5'b0};
      end
      ISR: in_isr = 1'b1;
      RETURN: begin
        in_isr      = 1'b1;
        pc_redirect = 1'b1;
        pc_target   = epc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer with a redirect-target scoreboard.
module tb_int_sequencer;

  logic        clk = 1'b0;
  logic        rst, irq, int_en, instr_boundary, reti;
  logic [31:0] vec_addr, pc_cur;
  logic        iack, pc_redirect, in_isr, stall, reti_err;
  logic [31:0] pc_target, epc;
  logic [7:0]  irq_count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          iack_seen = 0;
  int          exp_iack = 0;
  int          exp_cnt = 0;
  logic [31:0] exp_q[$];

  int_sequencer dut (
    .clk(clk), .rst(rst), .irq(irq), .vec_addr(vec_addr), .int_en(int_en),
    .instr_boundary(instr_boundary), .pc_cur(pc_cur), .reti(reti),
    .iack(iack), .pc_redirect(pc_redirect), .pc_target(pc_target), .epc(epc),
    .in_isr(in_isr), .stall(stall), .irq_count(irq_count), .reti_err(reti_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sat_cnt(input int c);
    return (c > 255) ? 8'hFF : c[7:0];
  endfunction

  // advance one edge; sample just after it and service the scoreboard
  task automatic tick();
    @(posedge clk);
    #1;
    if (iack) iack_seen++;
    if (pc_redirect) begin
      if (exp_q.size() == 0) chk("redir_unexpected", {31'b0, pc_redirect}, 32'h0);
      else                   chk("redir_target", pc_target, exp_q.pop_front());
    end else begin
      chk("target_idle_zero", pc_target, 32'h0);
    end
  endtask

  // full interrupt entry, one ISR cycle, reti, return to IDLE
  task automatic run_isr(input logic [31:0] v, input logic [31:0] pc);
    irq = 1'b1; vec_addr = v; int_en = 1'b1; instr_boundary = 1'b1; pc_cur = pc;
    exp_iack++;
    exp_q.push_back({v[31:5], 5'b0});
    tick();
    chk("run_iack", {31'b0, iack}, 32'h1);
    irq = 1'b0;
    tick();
    tick();
    exp_cnt++;
    chk("run_count", {24'b0, irq_count}, {24'b0, sat_cnt(exp_cnt)});
    chk("run_in_isr", {31'b0, in_isr}, 32'h1);
    chk("run_epc", epc, pc);
    reti = 1'b1;
    exp_q.push_back(pc);
    tick();
    reti = 1'b0;
    tick();
    chk("run_idle", {31'b0, in_isr}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; irq = 1'b0; int_en = 1'b0; instr_boundary = 1'b0; reti = 1'b0;
    vec_addr = '0; pc_cur = '0;

    // reset state
    tick(); tick();
    chk("rst_iack",  {31'b0, iack}, 32'h0);
    chk("rst_redir", {31'b0, pc_redirect}, 32'h0);
    chk("rst_epc",   epc, 32'h0);
    chk("rst_isr",   {31'b0, in_isr}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_cnt",   {24'b0, irq_count}, 32'h0);
    chk("rst_rerr",  {31'b0, reti_err}, 32'h0);
    rst = 1'b0;
    tick();

    // basic entry: vec 0x20, return address 0x104
    irq = 1'b1; vec_addr = 32'h20; int_en = 1'b1; instr_boundary = 1'b1; pc_cur = 32'h104;
    exp_iack++; exp_q.push_back(32'h20);
    tick();
    chk("n1_iack",  {31'b0, iack}, 32'h1);
    chk("n1_stall", {31'b0, stall}, 32'h1);
    chk("n1_epc",   epc, 32'h104);
    vec_addr = 32'h40; pc_cur = 32'h200;
    tick();
    chk("n2_redir", {31'b0, pc_redirect}, 32'h1);
    chk("n2_stall", {31'b0, stall}, 32'h1);
    chk("n2_iack",  {31'b0, iack}, 32'h0);
    tick();
    exp_cnt++;
    chk("n3_isr",   {31'b0, in_isr}, 32'h1);
    chk("n3_cnt",   {24'b0, irq_count}, {24'b0, sat_cnt(exp_cnt)});
    chk("n3_stall", {31'b0, stall}, 32'h0);
    // irq held high in ISR: no nesting
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("isr_no_iack", {31'b0, iack}, 32'h0);
      chk("isr_hold",    {31'b0, in_isr}, 32'h1);
    end
    chk("isr_epc_hold", epc, 32'h104);
    reti = 1'b1; exp_q.push_back(32'h104);
    tick();
    chk("ret_isr", {31'b0, in_isr}, 32'h1);
    reti = 1'b0;
    exp_iack++; exp_q.push_back(32'h40);
    tick();
    chk("ret_idle", {31'b0, in_isr}, 32'h0);
    tick();
    chk("b2b_iack", {31'b0, iack}, 32'h1);
    chk("b2b_epc",  epc, 32'h200);
    irq = 1'b0;
    tick(); tick();
    exp_cnt++;
    chk("b2b_cnt", {24'b0, irq_count}, {24'b0, sat_cnt(exp_cnt)});
    reti = 1'b1; exp_q.push_back(32'h200);
    tick();
    reti = 1'b0;
    tick();

    // gating by int_en and instr_boundary
    irq = 1'b1; vec_addr = 32'h6F; pc_cur = 32'h300;
    int_en = 1'b0; instr_boundary = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gate_en_iack",  {31'b0, iack}, 32'h0);
      chk("gate_en_stall", {31'b0, stall}, 32'h0);
    end
    int_en = 1'b1; instr_boundary = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gate_ib_iack", {31'b0, iack}, 32'h0);
    end
    instr_boundary = 1'b1;
    exp_iack++; exp_q.push_back(32'h60);
    tick();
    chk("gate_iack", {31'b0, iack}, 32'h1);
    irq = 1'b0; vec_addr = 32'hFFFF_FFFF;   // irq dropped in ACK; latched vector wins
    tick();
    chk("drop_redir", {31'b0, pc_redirect}, 32'h1);
    tick();
    exp_cnt++;
    reti = 1'b1; exp_q.push_back(32'h300);
    tick();
    reti = 1'b0;
    tick();

    // reti outside a handler
    reti = 1'b1;
    tick();
    chk("rerr_pulse", {31'b0, reti_err}, 32'h1);
    chk("rerr_idle",  {31'b0, in_isr}, 32'h0);
    reti = 1'b0;
    tick();
    chk("rerr_clear", {31'b0, reti_err}, 32'h0);
    chk("rerr_noack", {31'b0, iack}, 32'h0);

    // reset in the ACK cycle
    irq = 1'b1; vec_addr = 32'h80; pc_cur = 32'h400;
    exp_iack++;
    tick();
    chk("rack_iack", {31'b0, iack}, 32'h1);
    rst = 1'b1;
    tick();
    exp_cnt = 0;
    chk("rack_iack0",  {31'b0, iack}, 32'h0);
    chk("rack_redir0", {31'b0, pc_redirect}, 32'h0);
    chk("rack_epc0",   epc, 32'h0);
    chk("rack_cnt0",   {24'b0, irq_count}, 32'h0);
    chk("rack_stall0", {31'b0, stall}, 32'h0);
    rst = 1'b0;
    run_isr(32'h80, 32'h400);

    // saturation: 257 more taken interrupts from a count of 1
    for (int i = 0; i < 257; i++)
      run_isr($urandom, $urandom);
    chk("sat_cnt", {24'b0, irq_count}, 32'hFF);

    chk("sb_empty",  exp_q.size(), 32'h0);
    chk("iack_total", iack_seen, exp_iack);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
